// File: rtl/fib_seq_gen.sv
// fib_seq_gen
// Parametrised Fibonacci term generator with a valid/ready output port.
// Each accepted step emits the current first term (a) and advances the pair.
// When a + b does not fit in WIDTH bits, OVF_MODE selects what happens next:
//   0 = wrap modulo 2^WIDTH
//   1 = restart from the seeds
//   2 = halt until the next load or reset
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   load       reload term registers from load_a/load_b (highest priority)
//   load_a     new first term
//   load_b     new second term
//   step       request next term
//   out_ready  downstream accepts out_data
//   out_valid  out_data holds an unconsumed term
//   out_data   emitted term
//   out_ovf    sum computed on the step that produced out_data overflowed
//   halted     generator stopped after overflow (OVF_MODE 2)
//   count      accepted steps since reset/load, wraps silently
module fib_seq_gen #(
  parameter int WIDTH     = 8,
  parameter int SEED_A    = 0,
  parameter int SEED_B    = 1,
  parameter int OVF_MODE  = 0,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [WIDTH-1:0]     load_a,
  input  logic [WIDTH-1:0]     load_b,
  input  logic                 step,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_ovf,
  output logic                 halted,
  output logic [CNT_WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] SEED_A_W = WIDTH'(SEED_A);
  localparam logic [WIDTH-1:0] SEED_B_W = WIDTH'(SEED_B);

  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic                 out_valid_q, out_valid_d;
  logic [WIDTH-1:0]     out_data_q, out_data_d;
  logic                 out_ovf_q, out_ovf_d;
  logic                 halted_q, halted_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;

  logic                 step_acc;
  logic [WIDTH:0]       sum;
  logic                 carry;

  // A step is taken only when the output register is free or being drained
  // this same cycle; there is no skid buffer behind it.
  assign step_acc = step & ~load & ~halted_q & (~out_valid_q | out_ready);
  assign sum      = {1'b0, a_q} + {1'b0, b_q};
  assign carry    = sum[WIDTH];

  always_comb begin
    a_d         = a_q;
    b_d         = b_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ovf_d   = out_ovf_q;
    halted_d    = halted_q;
    count_d     = count_q;

    if (load) begin
      // Any pending term is dropped; out_data/out_ovf keep their old value.
      a_d         = load_a;
      b_d         = load_b;
      count_d     = '0;
      halted_d    = 1'b0;
      out_valid_d = 1'b0;
    end else if (step_acc) begin
      out_data_d  = a_q;
      out_ovf_d   = carry;
      out_valid_d = 1'b1;
      count_d     = count_q + CNT_WIDTH'(1);
      if (!carry || OVF_MODE == 0) begin
        a_d = b_q;
        b_d = sum[WIDTH-1:0];
      end else if (OVF_MODE == 1) begin
        a_d = SEED_A_W;
        b_d = SEED_B_W;
      end else begin
        // Freeze the pair so a later inspection shows where it stopped.
        halted_d = 1'b1;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q         <= SEED_A_W;
      b_q         <= SEED_B_W;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
      halted_q    <= 1'b0;
      count_q     <= '0;
    end else begin
      a_q         <= a_d;
      b_q         <= b_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ovf_q   <= out_ovf_d;
      halted_q    <= halted_d;
      count_q     <= count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;
  assign halted    = halted_q;
  assign count     = count_q;

endmodule

// File: tb/tb_fib_seq_gen.sv
// Bench for fib_seq_gen: three instances (OVF_MODE 0, 1, 2, default widths)
// share one directed stimulus. A behavioural model per mode is checked
// every cycle, and literal term tables pin the expected sequences.
module tb_fib_seq_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ld = 1'b0;
  logic [7:0] la = '0;
  logic [7:0] lb = '0;
  logic st = 1'b0;
  logic rdy = 1'b0;

  logic        ov [3];
  logic [7:0]  od [3];
  logic        oo [3];
  logic        oh [3];
  logic [15:0] oc [3];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    fib_seq_gen #(.WIDTH(8), .SEED_A(0), .SEED_B(1), .OVF_MODE(gi), .CNT_WIDTH(16)) u_dut (
      .clk(clk), .rst(rst), .load(ld), .load_a(la), .load_b(lb),
      .step(st), .out_ready(rdy), .out_valid(ov[gi]), .out_data(od[gi]),
      .out_ovf(oo[gi]), .halted(oh[gi]), .count(oc[gi])
    );
  end

  int passed = 0;
  int total = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int a; int b; int v; int d; int o; int h; int cnt;
  } mdl_t;

  mdl_t mdl [3];

  function automatic mdl_t mdl_reset();
    mdl_t r;
    r.a = 0; r.b = 1; r.v = 0; r.d = 0; r.o = 0; r.h = 0; r.cnt = 0;
    return r;
  endfunction

  function automatic mdl_t mdl_next(mdl_t m, int mode, bit l, int lav, int lbv, bit s, bit r);
    mdl_t n = m;
    int total_sum;
    if (l) begin
      n.a = lav; n.b = lbv; n.cnt = 0; n.h = 0; n.v = 0;
    end else if (s && m.h == 0 && (m.v == 0 || r)) begin
      total_sum = m.a + m.b;
      n.d = m.a;
      n.o = (total_sum > 255) ? 1 : 0;
      n.v = 1;
      n.cnt = (m.cnt + 1) % 65536;
      if (total_sum <= 255 || mode == 0) begin
        n.a = m.b; n.b = total_sum % 256;
      end else if (mode == 1) begin
        n.a = 0; n.b = 1;
      end else begin
        n.h = 1;
      end
    end else if (m.v == 1 && r) begin
      n.v = 0;
    end
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) mdl[i] <= mdl_reset();
      else     mdl[i] <= mdl_next(mdl[i], i, ld, int'(la), int'(lb), st, rdy);
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("m%0d out_valid", i), int'(ov[i]), mdl[i].v);
        chk($sformatf("m%0d out_data", i), int'(od[i]), mdl[i].d);
        chk($sformatf("m%0d out_ovf", i), int'(oo[i]), mdl[i].o);
        chk($sformatf("m%0d halted", i), int'(oh[i]), mdl[i].h);
        chk($sformatf("m%0d count", i), int'(oc[i]), mdl[i].cnt);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  int e0 [17] = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233, 121, 98, 219};
  int e1 [17] = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 0, 1, 1, 2};
  int el [4]  = '{3, 4, 7, 11};
  int er [4]  = '{0, 1, 1, 2};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tick();
    tick();
    rst = 1'b0;
    chk("reset out_valid", int'(ov[0]), 0);
    chk("reset out_data", int'(od[0]), 0);
    chk("reset out_ovf", int'(oo[0]), 0);
    chk("reset halted", int'(oh[2]), 0);
    chk("reset count", int'(oc[0]), 0);

    // Free run with step and out_ready high.
    st = 1'b1;
    rdy = 1'b1;
    for (int k = 0; k < 17; k++) begin
      tick();
      chk($sformatf("run m0 term%0d", k), int'(od[0]), e0[k]);
      chk($sformatf("run m1 term%0d", k), int'(od[1]), e1[k]);
      if (k <= 12) chk($sformatf("run m0 ovf%0d", k), int'(oo[0]), (k == 12) ? 1 : 0);
      if (k == 12) chk("run m1 ovf144", int'(oo[1]), 1);
      if (k == 13) chk("run m0 count14", int'(oc[0]), 14);
      if (k < 13) begin
        chk($sformatf("run m2 term%0d", k), int'(od[2]), e1[k]);
        chk($sformatf("run m2 valid%0d", k), int'(ov[2]), 1);
      end else begin
        chk($sformatf("run m2 idle%0d", k), int'(ov[2]), 0);
      end
      if (k >= 12) chk($sformatf("run m2 halted%0d", k), int'(oh[2]), 1);
    end
    chk("run m1 count17", int'(oc[1]), 17);

    // Drain, then load(3,4) which also clears halt.
    st = 1'b0;
    tick();
    ld = 1'b1; la = 8'd3; lb = 8'd4;
    tick();
    ld = 1'b0;
    chk("load m2 halted", int'(oh[2]), 0);
    chk("load m2 count", int'(oc[2]), 0);
    chk("load m0 valid", int'(ov[0]), 0);
    st = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      for (int i = 0; i < 3; i++)
        chk($sformatf("load m%0d term%0d", i, k), int'(od[i]), el[k]);
    end
    st = 1'b0;
    tick();

    // Back-pressure: first term held while out_ready is low.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    st = 1'b1;
    rdy = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("bp valid%0d", k), int'(ov[0]), 1);
      chk($sformatf("bp data%0d", k), int'(od[0]), 0);
      chk($sformatf("bp count%0d", k), int'(oc[0]), 1);
    end
    rdy = 1'b1;
    tick();
    chk("bp release data", int'(od[0]), 1);
    chk("bp release count", int'(oc[0]), 2);

    // Load together with step while a term is pending.
    rdy = 1'b0;
    ld = 1'b1; la = 8'd10; lb = 8'd20;
    tick();
    ld = 1'b0;
    chk("ldstep valid", int'(ov[0]), 0);
    chk("ldstep count", int'(oc[0]), 0);
    rdy = 1'b1;
    tick();
    chk("ldstep first", int'(od[0]), 10);
    chk("ldstep first valid", int'(ov[0]), 1);
    tick();
    chk("ldstep second", int'(od[0]), 20);

    // Asynchronous reset between clock edges while a term is valid.
    #2;
    rst = 1'b1;
    #1;
    chk("arst out_valid", int'(ov[0]), 0);
    chk("arst out_data", int'(od[0]), 0);
    chk("arst out_ovf", int'(oo[0]), 0);
    chk("arst count", int'(oc[0]), 0);
    chk("arst halted", int'(oh[2]), 0);
    st = 1'b0;
    tick();
    rst = 1'b0;
    st = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("arst term%0d", k), int'(od[0]), er[k]);
    end
    st = 1'b0;
    tick();
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
